// File: rtl/cam_arb_pkg.sv
// rtl/cam_arb_pkg.sv - shared helpers, port-index width and state encoding for cam_lookup_arbiter
package cam_arb_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = clog2(MAX_PORTS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cam_arb_tag_fifo.sv
// rtl/cam_arb_tag_fifo.sv - first-word fall-through FIFO of issuing port indices
module cam_arb_tag_fifo
    import cam_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PORT_IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cam_lookup_arbiter.sv
// rtl/cam_lookup_arbiter.sv - round-robin sharing of the CAM lookup port; CAM_ARB_WR_YIELD_EN yields to table writes
module cam_lookup_arbiter
    import cam_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int CMP_WIDTH    = 32,
    parameter int DATA_WIDTH   = 3,
    parameter int MAX_INFLIGHT = 8,
    parameter int INIT_CYCLES  = 40
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*CMP_WIDTH-1:0] req_cmp_data,
    input  logic [NUM_PORTS*CMP_WIDTH-1:0] req_cmp_dmask,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic [NUM_PORTS-1:0]           resp_valid,
    output logic                           resp_hit,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           lookup_req,
    output logic [CMP_WIDTH-1:0]           lookup_cmp_data,
    output logic [CMP_WIDTH-1:0]           lookup_cmp_dmask,
    input  logic                           lookup_ack,
    input  logic                           lookup_hit,
    input  logic [DATA_WIDTH-1:0]          lookup_data,
    input  logic                           wr_pending,
    output logic                           init_done,
    output logic                           err_ack_underflow
);

    localparam int CNT_W = clog2(INIT_CYCLES + 1);

    arb_state_t            state;
    logic [CNT_W-1:0]      init_cnt;
    logic [PORT_IDX_W-1:0] last_grant;
    logic [PORT_IDX_W-1:0] grant_idx;
    logic [PORT_IDX_W-1:0] head_idx;
    logic                  grant_found;
    logic                  grant_en;
    logic                  stall;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CMP_WIDTH-1:0]  sel_key;
    logic [CMP_WIDTH-1:0]  sel_mask;

`ifdef CAM_ARB_WR_YIELD_EN
    assign stall = wr_pending;
`else
    logic unused_wr_pending;
    assign unused_wr_pending = wr_pending;
    assign stall = 1'b0;
`endif

    // First pass looks strictly above last_grant; the second wraps around from port 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && req_valid[i] && (PORT_IDX_W'(i) > last_grant)) begin
                grant_found = 1'b1;
                grant_idx   = PORT_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = PORT_IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_key  = '0;
        sel_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PORT_IDX_W'(i)) begin
                sel_key  = req_cmp_data[i*CMP_WIDTH +: CMP_WIDTH];
                sel_mask = req_cmp_dmask[i*CMP_WIDTH +: CMP_WIDTH];
            end
        end
    end

    // Occupancy alone gates the grant, keeping lookup_ack off the req_ready path.
    assign grant_en  = (state == ST_RUN) && !fifo_full && !stall && grant_found;
    assign req_ready = grant_en ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign fifo_pop  = lookup_ack & ~fifo_empty;

    cam_arb_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (PORT_IDX_W)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (grant_en),
        .pop     (fifo_pop),
        .din     (grant_idx),
        .dout    (head_idx),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_INIT;
            init_cnt          <= '0;
            init_done         <= 1'b0;
            last_grant        <= PORT_IDX_W'(NUM_PORTS - 1);
            lookup_req        <= 1'b0;
            lookup_cmp_data   <= '0;
            lookup_cmp_dmask  <= '0;
            resp_valid        <= '0;
            resp_hit          <= 1'b0;
            resp_data         <= '0;
            err_ack_underflow <= 1'b0;
        end else begin
            lookup_req <= grant_en;
            resp_valid <= '0;
            case (state)
                ST_INIT: begin
                    if (init_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
            endcase
            if (grant_en) begin
                last_grant       <= grant_idx;
                lookup_cmp_data  <= sel_key;
                lookup_cmp_dmask <= sel_mask;
            end
            if (lookup_ack) begin
                if (fifo_empty) begin
                    err_ack_underflow <= 1'b1;
                end else begin
                    resp_valid <= NUM_PORTS'(1) << head_idx;
                    resp_hit   <= lookup_hit;
                    resp_data  <= lookup_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_lookup_arbiter.sv
// tb/tb_cam_lookup_arbiter.sv - randomized scoreboard bench with a 5-cycle CAM engine model
module tb_cam_lookup_arbiter;

    localparam int NP = 4;
    localparam int CW = 32;
    localparam int DW = 3;
    localparam int MI = 8;
    localparam int IC = 40;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP-1:0]    req_valid;
    logic [NP*CW-1:0] req_cmp_data;
    logic [NP*CW-1:0] req_cmp_dmask;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    resp_valid;
    logic             resp_hit;
    logic [DW-1:0]    resp_data;
    logic             lookup_req;
    logic [CW-1:0]    lookup_cmp_data;
    logic [CW-1:0]    lookup_cmp_dmask;
    logic             lookup_ack;
    logic             lookup_hit;
    logic [DW-1:0]    lookup_data;
    logic             wr_pending;
    logic             init_done;
    logic             err_ack_underflow;

    always #5 clk = ~clk;

    cam_lookup_arbiter #(
        .NUM_PORTS    (NP),
        .CMP_WIDTH    (CW),
        .DATA_WIDTH   (DW),
        .MAX_INFLIGHT (MI),
        .INIT_CYCLES  (IC)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_cmp_data      (req_cmp_data),
        .req_cmp_dmask     (req_cmp_dmask),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_data         (resp_data),
        .lookup_req        (lookup_req),
        .lookup_cmp_data   (lookup_cmp_data),
        .lookup_cmp_dmask  (lookup_cmp_dmask),
        .lookup_ack        (lookup_ack),
        .lookup_hit        (lookup_hit),
        .lookup_data       (lookup_data),
        .wr_pending        (wr_pending),
        .init_done         (init_done),
        .err_ack_underflow (err_ack_underflow)
    );

    logic [CW-1:0] tbl_key [8];
    logic [DW-1:0] tbl_data [8];

    // Table lookup: dmask bits set to 1 are don't-care; first matching entry wins.
    function automatic logic [DW:0] lut(input logic [CW-1:0] k, input logic [CW-1:0] m);
        logic [DW:0] r;
        logic        f;
        r = '0;
        f = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!f && (((k ^ tbl_key[i]) & ~m) == '0)) begin
                f = 1'b1;
                r = {1'b1, tbl_data[i]};
            end
        end
        return r;
    endfunction

    logic        pv [6];
    logic [DW:0] pr [6];
    logic        inj_ack;

    initial begin
        lookup_ack  = 1'b0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int j = 0; j < 6; j++) begin
            pv[j] = 1'b0;
            pr[j] = '0;
        end
        forever begin
            @(negedge clk);
            for (int j = 5; j > 0; j--) begin
                pv[j] = pv[j-1];
                pr[j] = pr[j-1];
            end
            pv[0]       = lookup_req;
            pr[0]       = lut(lookup_cmp_data, lookup_cmp_dmask);
            lookup_ack  = pv[5] | inj_ack;
            lookup_hit  = pv[5] ? pr[5][DW] : 1'b0;
            lookup_data = pv[5] ? pr[5][DW-1:0] : '0;
        end
    end

    typedef struct {
        int            port;
        logic          hit;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q [$];
    int            cyc;
    int            m_last;
    logic          exp_lreq;
    logic [CW-1:0] exp_key;
    logic [CW-1:0] exp_mask;
    int            checks;
    int            failures;

    task automatic model_reset();
        exp_q.delete();
        m_last   = NP - 1;
        exp_lreq = 1'b0;
        exp_key  = '0;
        exp_mask = '0;
    endtask

    task automatic test_reset_init();
        reset_n       = 1'b0;
        wr_pending    = 1'b0;
        req_valid     = '1;
        req_cmp_data  = {NP{32'h1234_5678}};
        req_cmp_dmask = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_data, lookup_req, lookup_cmp_data,
             lookup_cmp_dmask, init_done, err_ack_underflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b resp=%b lreq=%b init_done=%b err=%b expected all 0",
                     req_ready, resp_valid, lookup_req, init_done, err_ack_underflow);
        end
        reset_n = 1'b1;
        model_reset();
        for (int k = 1; k <= IC; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (init_done !== (k >= IC) || req_ready !== ((k >= IC) ? NP'(1) : NP'(0))) begin
                failures++;
                $display("FAIL init_gate k=%0d init_done=%b ready=%b expected init_done=%b ready=%b",
                         k, init_done, req_ready, (k >= IC), ((k >= IC) ? NP'(1) : NP'(0)));
            end
        end
        req_valid = '0;
        cyc = 0;
    endtask

    // mode 0: all ports saturated, 1: random, 2: directed hit/miss, 3: wr_pending window
    task automatic test_traffic(input int mode, input int ncyc);
        logic [NP-1:0] v;
        logic [NP-1:0] exp_ready;
        logic [CW-1:0] kk [NP];
        logic [CW-1:0] mk [NP];
        logic [CW-1:0] tmp;
        logic [DW:0]   res;
        logic          wp;
        logic          stall;
        exp_t          e;
        int            sel;
        int            p;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (resp_valid !== (NP'(1) << e.port) || resp_hit !== e.hit || resp_data !== e.data) begin
                    failures++;
                    $display("FAIL resp c=%0d valid=%b hit=%b data=%0d expected valid=%b hit=%b data=%0d",
                             cyc, resp_valid, resp_hit, resp_data, NP'(1) << e.port, e.hit, e.data);
                end
                if (mode == 2 && (e.port == 2 || e.port == 1)) begin
                    checks++;
                    if (resp_hit !== (e.port == 2) || resp_data !== ((e.port == 2) ? 3'd5 : 3'd0)) begin
                        failures++;
                        $display("FAIL hit_miss port=%0d hit=%b data=%0d expected hit=%b data=%0d",
                                 e.port, resp_hit, resp_data, (e.port == 2), (e.port == 2) ? 5 : 0);
                    end
                end
            end else begin
                checks++;
                if (resp_valid !== '0) begin
                    failures++;
                    $display("FAIL resp_idle c=%0d valid=%b expected 0", cyc, resp_valid);
                end
            end
            checks++;
            if (lookup_req !== exp_lreq || lookup_cmp_data !== exp_key || lookup_cmp_dmask !== exp_mask) begin
                failures++;
                $display("FAIL lookup c=%0d req=%b key=%h mask=%h expected req=%b key=%h mask=%h",
                         cyc, lookup_req, lookup_cmp_data, lookup_cmp_dmask, exp_lreq, exp_key, exp_mask);
            end

            for (int i = 0; i < NP; i++) begin
                tmp = $urandom;
                if ($urandom_range(0, 1) == 1) kk[i] = tbl_key[$urandom_range(0, 7)];
                else                           kk[i] = tmp | 32'h8000_0000;
                mk[i] = ($urandom_range(0, 3) == 0) ? 32'h0000_00FF : 32'h0;
            end
            case (mode)
                0:       v = '1;
                1:       v = NP'($urandom);
                2:       v = (t == 0) ? NP'(4) : ((t == 1) ? NP'(2) : NP'(0));
                default: v = '1;
            endcase
            if (mode == 2) begin
                kk[2] = tbl_key[5];
                mk[2] = '0;
                kk[1] = 32'h8000_0001;
                mk[1] = '0;
            end
            wp = 1'b0;
            if (mode == 1) wp = ($urandom_range(0, 7) == 0);
            if (mode == 3) wp = (t >= 5 && t < 10);
            if (t >= ncyc - 10) begin
                v  = '0;
                wp = 1'b0;
            end
            req_valid  = v;
            wr_pending = wp;
            for (int i = 0; i < NP; i++) begin
                req_cmp_data[i*CW +: CW]  = kk[i];
                req_cmp_dmask[i*CW +: CW] = mk[i];
            end
            #1;
`ifdef CAM_ARB_WR_YIELD_EN
            stall = wp;
`else
            stall = 1'b0;
`endif
            sel = -1;
            if (!stall && exp_q.size() < MI) begin
                for (int k = 1; k <= NP; k++) begin
                    p = (m_last + k) % NP;
                    if (sel < 0 && v[p]) sel = p;
                end
            end
            exp_ready = (sel >= 0) ? (NP'(1) << sel) : NP'(0);
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL grant c=%0d mode=%0d valid=%b ready=%b expected %b",
                         cyc, mode, v, req_ready, exp_ready);
            end
            if (sel >= 0) begin
                res = lut(kk[sel], mk[sel]);
                exp_q.push_back('{sel, res[DW], res[DW-1:0], cyc + 7});
                m_last   = sel;
                exp_lreq = 1'b1;
                exp_key  = kk[sel];
                exp_mask = mk[sel];
            end else begin
                exp_lreq = 1'b0;
            end
        end
    endtask

    task automatic test_underflow();
        @(posedge clk);
        #1;
        checks++;
        if (err_ack_underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pre err=%b expected 0", err_ack_underflow);
        end
        inj_ack = 1'b1;
        @(posedge clk);
        #1;
        inj_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (err_ack_underflow !== 1'b1 || resp_valid !== '0) begin
                failures++;
                $display("FAIL underflow k=%0d err=%b resp=%b expected err=1 resp=0",
                         k, err_ack_underflow, resp_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_data, lookup_req, lookup_cmp_data,
             lookup_cmp_dmask, init_done, err_ack_underflow} !== '0) begin
            failures++;
            $display("FAIL async_reset ready=%b resp=%b lreq=%b init_done=%b err=%b expected all 0",
                     req_ready, resp_valid, lookup_req, init_done, err_ack_underflow);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        stale = 0;
        for (int k = 1; k <= IC + 4; k++) begin
            @(posedge clk);
            #1;
            if (lookup_ack) stale++;
            checks++;
            if (resp_valid !== '0 || init_done !== (k >= IC) || req_ready !== '0) begin
                failures++;
                $display("FAIL post_reset k=%0d resp=%b init_done=%b ready=%b expected resp=0 init_done=%b ready=0",
                         k, resp_valid, init_done, req_ready, (k >= IC));
            end
        end
        checks++;
        if (err_ack_underflow !== (stale > 0)) begin
            failures++;
            $display("FAIL stale_underflow err=%b expected %b (stale acks %0d)",
                     err_ack_underflow, (stale > 0), stale);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        inj_ack  = 1'b0;
        cyc      = 0;
        for (int i = 0; i < 8; i++) begin
            tbl_key[i]  = $urandom & 32'h7FFF_FF00;
            tbl_key[i]  = tbl_key[i] | (CW'(i) << 8);
            tbl_data[i] = DW'(i);
        end
        model_reset();
        test_reset_init();
        test_traffic(0, 40);
        test_traffic(2, 14);
        test_traffic(1, 300);
        test_traffic(3, 30);
        test_underflow();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
